branch_update_ctrl: RTL and testbench
=====================================

BRANCH_UPDATE_CTRL -- requirements
Module: branch_update_ctrl

Interface
REQ-001 SHALL expose parameter FIFO_DEPTH, default 4, meaning the number of resolved-branch updates buffered (power of two).
REQ-002 SHALL expose parameter INIT_PHT, default 2'b01, meaning the counter value written to every PHT entry during the init sweep.
REQ-003 clk  in  1  sole clock; all state updates on posedge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 clear  in  1  synchronous request to flush the FIFO and restart the init sweep.
REQ-006 stall  in  1  pipeline stall; when high, the resolve inputs are ignored.
REQ-007 resolve_valid  in  1  EX/MEM stage holds a resolved instruction.
REQ-008 resolve_is_ctrl  in  1  the resolved instruction is BR/JMP/JSR/TRAP.
REQ-009 resolve_pc  in  8  low PC bits of the resolved instruction.
REQ-010 resolve_taken  in  1  resolved branch direction.
REQ-011 resolve_target  in  16  resolved target address.
REQ-012 tbl_busy  in  1  predictor table write port unavailable this cycle.
REQ-013 upd_valid  out  1  table write is issued this cycle.
REQ-014 upd_pht_idx  out  8  PHT write index.
REQ-015 upd_pht_inc  out  1  1 = saturating increment, 0 = saturating decrement (RUN only).
REQ-016 upd_pht_init  out  1  write INIT_PHT instead of inc/dec.
REQ-017 upd_btb_we  out  1  BTB write enable.
REQ-018 upd_btb_idx  out  8  BTB write index.
REQ-019 upd_btb_data  out  16  BTB write data.
REQ-020 ghr  out  8  global branch history register.
REQ-021 init_busy  out  1  init sweep in progress.
REQ-022 fifo_full  out  1  FIFO occupancy == FIFO_DEPTH.
REQ-023 overflow  out  1  one-cycle pulse when a resolve is dropped.

Function
REQ-024 The FSM SHALL have states INIT and RUN; it enters INIT on reset or clear and leaves INIT for RUN after index 255 is written.
REQ-025 INIT SHALL write one entry per cycle with tbl_busy=0: upd_valid=1, upd_pht_init=1, upd_btb_we=1, upd_btb_data=0, pht_idx=btb_idx=sweep counter; the counter SHALL hold while tbl_busy=1.
REQ-026 Push SHALL occur when resolve_valid && resolve_is_ctrl && !stall && !clear, in either state; the entry stores {pc ^ ghr (pre-shift), pc, taken, target}.
REQ-027 On every accepted push, ghr SHALL become {ghr[6:0], resolve_taken} at the same edge.
REQ-028 A push while full with no same-cycle pop SHALL be dropped, pulse overflow the next cycle, and leave ghr unchanged.
REQ-029 Pop SHALL occur in RUN when the FIFO is not empty && !tbl_busy; upd_* is driven combinationally from the head: upd_valid=1, upd_pht_idx=stored index, upd_pht_inc=taken, upd_pht_init=0, upd_btb_we=taken, upd_btb_idx=pc, upd_btb_data=target.
REQ-030 A simultaneous push and pop when full SHALL be accepted; occupancy is unchanged.
REQ-031 Latency: an entry pushed at edge N SHALL be eligible for upd at cycle N+1 (FIFO empty, RUN, tbl_busy=0).
REQ-032 Pointers SHALL wrap modulo FIFO_DEPTH; occupancy SHALL range 0..FIFO_DEPTH.
REQ-033 In any state not otherwise listed, upd_valid SHALL be 0 and all upd_* write enables SHALL be 0.
REQ-034 Clear SHALL empty the FIFO, zero ghr, zero the sweep counter and enter INIT at the next edge; clear during INIT SHALL restart the sweep at 0.
REQ-035 Pushes during INIT SHALL be buffered and drained only after the transition to RUN.

Reset
REQ-036 When reset_n=0, the block SHALL immediately reach state INIT, sweep counter 0, FIFO empty, ghr=0, overflow=0; init_busy SHALL be 1 and fifo_full 0.
REQ-037 Reset asserted mid-sweep or mid-drain SHALL discard all progress; the sweep restarts at 0 after release.

Verification
REQ-038 Release reset with tbl_busy=0 -> 256 consecutive init writes with idx 0..255, then init_busy=0 at cycle 256.
REQ-039 RUN, ghr=8'h0F, push pc=8'h30 taken target=16'h1234 -> next cycle upd_pht_idx=8'h3F, upd_pht_inc=1, upd_btb_we=1, upd_btb_idx=8'h30, upd_btb_data=16'h1234; ghr=8'h1F.
REQ-040 tbl_busy=1 with 5 pushes -> fifo_full=1 after 4; the 5th is dropped with an overflow pulse, and ghr reflects 4 shifts only.
REQ-041 Full FIFO with tbl_busy=0 plus push the same cycle -> pop and push both taken, occupancy stays 4, no overflow.
REQ-042 Clear at sweep index 100 -> next write at index 0; FIFO empty; ghr=0.
REQ-043 Push with stall=1 or resolve_is_ctrl=0 -> no FIFO change, ghr unchanged.

Source files
------------

// File: rtl/branch_update_ctrl.sv
// Branch predictor update controller: sweeps PHT/BTB to a known state after reset/clear,
// then buffers resolved control-flow updates and issues them through a single table write port.
module branch_update_ctrl #(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [1:0] INIT_PHT   = 2'b01
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        stall,
    input  logic        resolve_valid,
    input  logic        resolve_is_ctrl,
    input  logic [7:0]  resolve_pc,
    input  logic        resolve_taken,
    input  logic [15:0] resolve_target,
    input  logic        tbl_busy,
    output logic        upd_valid,
    output logic [7:0]  upd_pht_idx,
    output logic        upd_pht_inc,
    output logic        upd_pht_init,
    output logic        upd_btb_we,
    output logic [7:0]  upd_btb_idx,
    output logic [15:0] upd_btb_data,
    output logic [7:0]  ghr,
    output logic        init_busy,
    output logic        fifo_full,
    output logic        overflow
);

    localparam int              AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0]     DEPTH_C = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW-1:0]   LAST_C  = AW'(FIFO_DEPTH - 1);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || $bits(INIT_PHT) != 2) begin : g_bad_params
        $error("branch_update_ctrl: FIFO_DEPTH must be a power of two >= 2");
    end

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    typedef struct packed {
        logic [7:0]  idx;
        logic [7:0]  pc;
        logic        taken;
        logic [15:0] target;
    } entry_t;

    state_t        state;
    logic [7:0]    sweep_idx;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    entry_t        mem [FIFO_DEPTH];
    entry_t        head;

    logic push_req;
    logic fifo_empty;
    logic do_pop;
    logic do_push;
    logic drop;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == LAST_C) ? '0 : p + 1'b1;
    endfunction

    assign head       = mem[rd_ptr];
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == DEPTH_C);
    assign init_busy  = (state == INIT);
    assign push_req   = resolve_valid && resolve_is_ctrl && !stall && !clear;
    assign do_pop     = (state == RUN) && !fifo_empty && !tbl_busy;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign do_push    = push_req && (!fifo_full || do_pop);
    assign drop       = push_req && fifo_full && !do_pop;

    always_comb begin
        upd_valid    = 1'b0;
        upd_pht_idx  = '0;
        upd_pht_inc  = 1'b0;
        upd_pht_init = 1'b0;
        upd_btb_we   = 1'b0;
        upd_btb_idx  = '0;
        upd_btb_data = '0;
        if (state == INIT && !tbl_busy) begin
            upd_valid    = 1'b1;
            upd_pht_idx  = sweep_idx;
            upd_pht_init = 1'b1;
            upd_btb_we   = 1'b1;
            upd_btb_idx  = sweep_idx;
        end else if (do_pop) begin
            upd_valid    = 1'b1;
            upd_pht_idx  = head.idx;
            upd_pht_inc  = head.taken;
            upd_btb_we   = head.taken;
            upd_btb_idx  = head.pc;
            upd_btb_data = head.target;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= '{idx: resolve_pc ^ ghr, pc: resolve_pc,
                             taken: resolve_taken, target: resolve_target};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= INIT;
            sweep_idx <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            ghr       <= '0;
            overflow  <= 1'b0;
        end else if (clear) begin
            state     <= INIT;
            sweep_idx <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            ghr       <= '0;
            overflow  <= 1'b0;
        end else begin
            overflow <= drop;
            if (do_push) begin
                wr_ptr <= next_ptr(wr_ptr);
                ghr    <= {ghr[6:0], resolve_taken};
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
            case (state)
                INIT: begin
                    if (!tbl_busy) begin
                        sweep_idx <= sweep_idx + 8'd1;
                        if (sweep_idx == 8'hFF) begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_update_ctrl.sv
// Directed bench for branch_update_ctrl: vector table for push/pop behaviour plus
// hand-written sequences for sweep, overflow, full push+pop, clear and reset.
module tb_branch_update_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clear;
    logic        stall;
    logic        resolve_valid;
    logic        resolve_is_ctrl;
    logic [7:0]  resolve_pc;
    logic        resolve_taken;
    logic [15:0] resolve_target;
    logic        tbl_busy;
    logic        upd_valid;
    logic [7:0]  upd_pht_idx;
    logic        upd_pht_inc;
    logic        upd_pht_init;
    logic        upd_btb_we;
    logic [7:0]  upd_btb_idx;
    logic [15:0] upd_btb_data;
    logic [7:0]  ghr;
    logic        init_busy;
    logic        fifo_full;
    logic        overflow;

    int n_checks = 0;
    int n_fail   = 0;

    branch_update_ctrl #(.FIFO_DEPTH(4), .INIT_PHT(2'b01)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .clear           (clear),
        .stall           (stall),
        .resolve_valid   (resolve_valid),
        .resolve_is_ctrl (resolve_is_ctrl),
        .resolve_pc      (resolve_pc),
        .resolve_taken   (resolve_taken),
        .resolve_target  (resolve_target),
        .tbl_busy        (tbl_busy),
        .upd_valid       (upd_valid),
        .upd_pht_idx     (upd_pht_idx),
        .upd_pht_inc     (upd_pht_inc),
        .upd_pht_init    (upd_pht_init),
        .upd_btb_we      (upd_btb_we),
        .upd_btb_idx     (upd_btb_idx),
        .upd_btb_data    (upd_btb_data),
        .ghr             (ghr),
        .init_busy       (init_busy),
        .fifo_full       (fifo_full),
        .overflow        (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        valid;
        logic        is_ctrl;
        logic [7:0]  pc;
        logic        taken;
        logic [15:0] target;
        logic        exp_valid;
        logic [7:0]  exp_idx;
        logic        exp_inc;
        logic        exp_btb_we;
        logic [15:0] exp_data;
        logic [7:0]  exp_ghr;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        clear           = 1'b0;
        stall           = 1'b0;
        resolve_valid   = 1'b0;
        resolve_is_ctrl = 1'b0;
        resolve_pc      = '0;
        resolve_taken   = 1'b0;
        resolve_target  = '0;
    endtask

    task automatic drive_push(input logic [7:0] pc, input logic taken, input logic [15:0] tgt);
        clear           = 1'b0;
        stall           = 1'b0;
        resolve_valid   = 1'b1;
        resolve_is_ctrl = 1'b1;
        resolve_pc      = pc;
        resolve_taken   = taken;
        resolve_target  = tgt;
    endtask

    task automatic chk_pop(input string tag, input logic [7:0] idx, input logic [7:0] pc,
                           input logic taken, input logic [15:0] data);
        chk({tag, "_valid"}, upd_valid, 1'b1);
        chk({tag, "_init"}, upd_pht_init, 1'b0);
        chk({tag, "_idx"}, upd_pht_idx, idx);
        chk({tag, "_inc"}, upd_pht_inc, taken);
        chk({tag, "_btb_we"}, upd_btb_we, taken);
        chk({tag, "_btb_idx"}, upd_btb_idx, pc);
        chk({tag, "_btb_data"}, upd_btb_data, data);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int unsigned exp_idx;
        int unsigned cyc;
        logic        busy;
        logic [7:0]  ovf_pc  [5] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        logic        ovf_tk  [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [15:0] ovf_tg  [5] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
        logic [7:0]  dr_idx  [4] = '{8'hF7, 8'hE9, 8'hD1, 8'hAD};
        logic [7:0]  dr_pc   [4] = '{8'h02, 8'h03, 8'h04, 8'h06};
        logic        dr_tk   [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic [15:0] dr_tg   [4] = '{16'h2222, 16'h3333, 16'h4444, 16'h6666};

        // stall valid ctrl pc taken target | exp_valid idx inc btb_we data ghr
        vecs[0]  = '{0, 1, 1, 8'h10, 1, 16'hAAAA, 1, 8'h10, 1, 1, 16'hAAAA, 8'h01};
        vecs[1]  = '{0, 1, 1, 8'h21, 1, 16'h0102, 1, 8'h20, 1, 1, 16'h0102, 8'h03};
        vecs[2]  = '{0, 1, 1, 8'h22, 1, 16'hBEEF, 1, 8'h21, 1, 1, 16'hBEEF, 8'h07};
        vecs[3]  = '{0, 1, 1, 8'hF0, 1, 16'h5555, 1, 8'hF7, 1, 1, 16'h5555, 8'h0F};
        vecs[4]  = '{0, 1, 1, 8'h30, 1, 16'h1234, 1, 8'h3F, 1, 1, 16'h1234, 8'h1F};
        vecs[5]  = '{0, 1, 1, 8'h44, 0, 16'h9999, 1, 8'h5B, 0, 0, 16'h9999, 8'h3E};
        vecs[6]  = '{1, 1, 1, 8'h55, 1, 16'h7777, 0, 8'h00, 0, 0, 16'h0000, 8'h3E};
        vecs[7]  = '{0, 1, 0, 8'h55, 1, 16'h7777, 0, 8'h00, 0, 0, 16'h0000, 8'h3E};
        vecs[8]  = '{0, 0, 1, 8'h55, 1, 16'h7777, 0, 8'h00, 0, 0, 16'h0000, 8'h3E};
        vecs[9]  = '{0, 1, 1, 8'hFF, 1, 16'hFFFF, 1, 8'hC1, 1, 1, 16'hFFFF, 8'h7D};
        vecs[10] = '{0, 1, 1, 8'h00, 0, 16'h0000, 1, 8'h7D, 0, 0, 16'h0000, 8'hFA};

        set_idle();
        tbl_busy = 1'b0;
        reset_n  = 1'b0;
        #2;
        chk("rst_init_busy", init_busy, 1'b1);
        chk("rst_fifo_full", fifo_full, 1'b0);
        chk("rst_ghr", ghr, 8'h00);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_upd_idx", upd_pht_idx, 8'h00);
        tick();
        reset_n = 1'b1;

        // Init sweep with a 3-cycle tbl_busy hold in the middle.
        exp_idx = 0;
        cyc = 0;
        while (exp_idx < 256 && cyc < 400) begin
            busy = (cyc >= 50 && cyc < 53);
            tbl_busy = busy;
            #4;
            chk("sweep_init_busy", init_busy, 1'b1);
            chk("sweep_valid", upd_valid, !busy);
            if (!busy) begin
                chk("sweep_pht_idx", upd_pht_idx, exp_idx[7:0]);
                chk("sweep_btb_idx", upd_btb_idx, exp_idx[7:0]);
                chk("sweep_pht_init", upd_pht_init, 1'b1);
                chk("sweep_btb_we", upd_btb_we, 1'b1);
                chk("sweep_btb_data", upd_btb_data, 16'h0000);
                exp_idx++;
            end else begin
                chk("sweep_hold_we", upd_btb_we, 1'b0);
            end
            tick();
            cyc++;
        end
        chk("sweep_complete", exp_idx, 256);
        tbl_busy = 1'b0;
        #4;
        chk("run_init_busy", init_busy, 1'b0);
        chk("run_idle_valid", upd_valid, 1'b0);

        for (int i = 0; i < 11; i++) begin
            tick();
            stall           = vecs[i].stall;
            resolve_valid   = vecs[i].valid;
            resolve_is_ctrl = vecs[i].is_ctrl;
            resolve_pc      = vecs[i].pc;
            resolve_taken   = vecs[i].taken;
            resolve_target  = vecs[i].target;
            #4;
            chk("vec_pre_valid", upd_valid, 1'b0);
            tick();
            set_idle();
            #4;
            chk("vec_valid", upd_valid, vecs[i].exp_valid);
            chk("vec_btb_we", upd_btb_we, vecs[i].exp_btb_we);
            chk("vec_pht_init", upd_pht_init, 1'b0);
            chk("vec_ghr", ghr, vecs[i].exp_ghr);
            if (vecs[i].exp_valid) begin
                chk("vec_pht_idx", upd_pht_idx, vecs[i].exp_idx);
                chk("vec_pht_inc", upd_pht_inc, vecs[i].exp_inc);
                chk("vec_btb_idx", upd_btb_idx, vecs[i].pc);
                chk("vec_btb_data", upd_btb_data, vecs[i].exp_data);
            end
        end

        // Fill with table busy; the fifth push is dropped.
        for (int k = 0; k < 5; k++) begin
            tick();
            tbl_busy = 1'b1;
            drive_push(ovf_pc[k], ovf_tk[k], ovf_tg[k]);
            #4;
            chk("fill_valid", upd_valid, 1'b0);
            chk("fill_full", fifo_full, (k == 4));
            chk("fill_overflow", overflow, 1'b0);
        end
        tick();
        set_idle();
        #4;
        chk("ovf_pulse", overflow, 1'b1);
        chk("ovf_ghr", ghr, 8'hAB);
        chk("ovf_full", fifo_full, 1'b1);
        tick();
        #4;
        chk("ovf_pulse_end", overflow, 1'b0);

        // Full FIFO, table free, push in same cycle: both accepted.
        tick();
        tbl_busy = 1'b0;
        drive_push(8'h06, 1'b1, 16'h6666);
        #4;
        chk("pp_full_before", fifo_full, 1'b1);
        chk_pop("pp_head", 8'hFB, 8'h01, 1'b1, 16'h1111);
        tick();
        set_idle();
        #4;
        chk("pp_full_after", fifo_full, 1'b1);
        chk("pp_overflow", overflow, 1'b0);
        chk("pp_ghr", ghr, 8'h57);
        for (int k = 0; k < 4; k++) begin
            chk_pop("drain", dr_idx[k], dr_pc[k], dr_tk[k], dr_tg[k]);
            tick();
            #4;
        end
        chk("drain_empty_valid", upd_valid, 1'b0);
        chk("drain_full", fifo_full, 1'b0);

        // Clear in RUN with a pending entry, then clear again at sweep index 100.
        tick();
        tbl_busy = 1'b1;
        drive_push(8'h12, 1'b1, 16'h0000);
        tick();
        set_idle();
        clear = 1'b1;
        #4;
        chk("clr_pre_ghr", ghr, 8'hAF);
        tick();
        clear    = 1'b0;
        tbl_busy = 1'b0;
        #4;
        chk("clr_init_busy", init_busy, 1'b1);
        chk("clr_ghr", ghr, 8'h00);
        chk("clr_idx", upd_pht_idx, 8'h00);
        chk("clr_pht_init", upd_pht_init, 1'b1);
        cyc = 0;
        while (upd_pht_idx != 8'd100 && cyc < 300) begin
            tick();
            #4;
            cyc++;
        end
        chk("clr100_reach", upd_pht_idx, 8'd100);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        #4;
        chk("clr100_idx", upd_pht_idx, 8'h00);
        chk("clr100_init_busy", init_busy, 1'b1);
        chk("clr100_ghr", ghr, 8'h00);
        tick();
        drive_push(8'h77, 1'b1, 16'h7777);
        #4;
        chk("init_push_idx", upd_pht_idx, 8'h01);
        tick();
        set_idle();
        #4;
        chk("init_push_ghr", ghr, 8'h01);
        chk("init_push_pht_init", upd_pht_init, 1'b1);
        chk("init_push_sweep_idx", upd_pht_idx, 8'h02);
        chk("init_push_data", upd_btb_data, 16'h0000);
        cyc = 0;
        while (init_busy && cyc < 300) begin
            tick();
            #4;
            cyc++;
        end
        chk("init_done", init_busy, 1'b0);
        chk_pop("init_buffered", 8'h77, 8'h77, 1'b1, 16'h7777);
        tick();
        #4;
        chk("init_buffered_drained", upd_valid, 1'b0);

        // Reset with a full FIFO discards everything.
        for (int k = 0; k < 4; k++) begin
            tick();
            tbl_busy = 1'b1;
            drive_push(8'h20 + 8'(k), 1'b1, 16'hCAFE);
        end
        tick();
        set_idle();
        #2;
        chk("mid_full", fifo_full, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_init_busy", init_busy, 1'b1);
        chk("mid_rst_ghr", ghr, 8'h00);
        chk("mid_rst_full", fifo_full, 1'b0);
        chk("mid_rst_overflow", overflow, 1'b0);
        chk("mid_rst_valid", upd_valid, 1'b0);
        tbl_busy = 1'b0;
        tick();
        reset_n = 1'b1;
        #4;
        chk("post_rst_valid", upd_valid, 1'b1);
        chk("post_rst_idx", upd_pht_idx, 8'h00);
        chk("post_rst_pht_init", upd_pht_init, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
